bcd_run_ctrl: RTL and testbench

//  Run controller for the 2-digit BCD counter (ones/tens, 00..99). It takes a

---
 rtl/bcd_run_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_bcd_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_run_ctrl.sv
// bcd_run_ctrl
//   Run controller for an external 2-digit BCD counter (00..99). It accepts a
//   command stream and paces the counter with a one-cycle enable every
//   PRESCALE clocks. It stops when the fed-back count reaches a programmable
//   BCD target and clears the counter on command.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid, cmd    command handshake: 00 START, 01 STOP, 10 CLEAR, 11 SET_TARGET
//   cmd_data          SET_TARGET payload {tens, ones} in BCD
//   cmd_ready         low only in CLR; a command is taken when cmd_valid && cmd_ready
//   ones, tens        counter digits fed back from the counter
//   cnt_en            one-cycle advance pulse to the counter
//   cnt_clr           one-cycle clear pulse to the counter
//   done              one-cycle pulse when the target is reached
//   busy              high while in RUN
//   err               one-cycle pulse when a SET_TARGET carries a digit > 9
//   state_o           debug view of the state register
//
// state | meaning
// IDLE  | stopped, waiting for START or CLEAR
// RUN   | prescaler running, counter advanced on each terminal cycle
// PAUSE | stopped by STOP, prescaler value held for resume
// CLR   | single cycle pulsing cnt_clr; commands are not accepted
// DONE  | target reached; sticky until CLEAR

module bcd_run_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [2:0] state_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_SET   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_CLR   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [7:0]    target_q, target_d;
  logic          cnt_en_d, done_d, err_d;

  logic          accept;
  logic          is_start, is_stop, is_clear, is_set;
  logic          terminal;
  logic          tgt_ok;
  logic [7:0]    count_eff;
  logic          hit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    accept   = cmd_valid && cmd_ready;
    is_start = accept && (cmd == CMD_START);
    is_stop  = accept && (cmd == CMD_STOP);
    is_clear = accept && (cmd == CMD_CLEAR);
    is_set   = accept && (cmd == CMD_SET);
    terminal = (p_q == P_LAST);
    tgt_ok   = (cmd_data[7:4] <= 4'd9) && (cmd_data[3:0] <= 4'd9);
    // cnt_en is registered, so an enable that is high this cycle has not yet
    // reached the digits. With PRESCALE = 1 that pulse overlaps the next
    // terminal, so compare against the value the counter is about to hold.
    count_eff = cnt_en ? bcd_inc({tens, ones}) : {tens, ones};
    hit       = (count_eff == target_q);
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    target_d = target_q;
    cnt_en_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (is_set) begin
      if (tgt_ok) target_d = cmd_data;
      else        err_d    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          state_d = S_RUN;
          p_d     = '0;
        end else if (is_clear) begin
          state_d = S_CLR;
        end
      end

      S_RUN: begin
        if (is_stop) begin
          state_d = S_PAUSE;
        end else if (is_clear) begin
          state_d = S_CLR;
        end else if (terminal) begin
          if (hit) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_en_d = 1'b1;
            p_d      = '0;
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end

      S_PAUSE: begin
        if (is_start) begin
          state_d = S_RUN;
          // A STOP taken on a terminal cycle left p at its last value; the
          // deferred step is evaluated on resume so its enable lands in the
          // first RUN cycle.
          if (terminal) begin
            if (hit) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_en_d = 1'b1;
              p_d      = '0;
            end
          end
        end else if (is_clear) begin
          state_d = S_CLR;
        end
      end

      S_CLR: begin
        p_d     = '0;
        state_d = S_IDLE;
      end

      S_DONE: begin
        if (is_clear) state_d = S_CLR;
      end

      default: begin
        state_d = S_IDLE;
        p_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      target_q  <= 8'h99;
      cmd_ready <= 1'b1;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      target_q  <= target_d;
      cmd_ready <= (state_d != S_CLR);
      cnt_en    <= cnt_en_d;
      cnt_clr   <= (state_d == S_CLR);
      done      <= done_d;
      busy      <= (state_d == S_RUN);
      err       <= err_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
module tb_bcd_run_ctrl;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_CLEAR = 2'b10;
  localparam logic [1:0] C_SET   = 2'b11;

  localparam logic [3:0] K_EN   = 4'b0001;
  localparam logic [3:0] K_DONE = 4'b0010;
  localparam logic [3:0] K_ERR  = 4'b0100;
  localparam logic [3:0] K_CLR  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [1:0] cmd_valid;
  logic [1:0] cmd      [2];
  logic [7:0] cmd_data [2];
  logic [1:0] cmd_ready, cnt_en, cnt_clr, done, busy, err;
  logic [2:0] state_o  [2];
  logic [7:0] cnt      [2];
  logic [1:0] ld;
  logic [7:0] ld_val;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  en_cnt [2];
  ev_t q0[$];
  ev_t q1[$];
  logic [3:0] mk;

  bcd_run_ctrl #(.PRESCALE(4)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd(cmd[0]),
    .cmd_data(cmd_data[0]), .cmd_ready(cmd_ready[0]),
    .ones(cnt[0][3:0]), .tens(cnt[0][7:4]),
    .cnt_en(cnt_en[0]), .cnt_clr(cnt_clr[0]), .done(done[0]),
    .busy(busy[0]), .err(err[0]), .state_o(state_o[0])
  );

  bcd_run_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd(cmd[1]),
    .cmd_data(cmd_data[1]), .cmd_ready(cmd_ready[1]),
    .ones(cnt[1][3:0]), .tens(cnt[1][7:4]),
    .cnt_en(cnt_en[1]), .cnt_clr(cnt_clr[1]), .done(done[1]),
    .busy(busy[1]), .err(err[1]), .state_o(state_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural model of the external BCD counter
  function automatic logic [7:0] count_next(input logic [7:0] v);
    int n;
    n = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || cnt_clr[i])  cnt[i] <= 8'h00;
      else if (ld[i])         cnt[i] <= ld_val;
      else if (cnt_en[i])     cnt[i] <= count_next(cnt[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int cy, input logic [3:0] k);
    ev_t e;
    e.cyc  = cy;
    e.kind = k;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_ev(input int d, input logic [3:0] k);
    ev_t e;
    int  n;
    n = (d == 0) ? q0.size() : q1.size();
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL pulse_unexpected dut%0d cyc %0d: got kind %b, wanted no pulse", d, cyc, k);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (e.cyc != cyc || e.kind != k) begin
        miscompares++;
        $display("FAIL pulse dut%0d: got kind %b at cyc %0d, wanted kind %b at cyc %0d",
                 d, k, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // monitor: every pulse the DUTs emit must match the next queued expectation
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mk = {cnt_clr[d], err[d], done[d], cnt_en[d]};
      if (cnt_en[d]) en_cnt[d] = en_cnt[d] + 1;
      if (mk != 4'b0000) check_ev(d, mk);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int d, input logic [1:0] c, input logic [7:0] data);
    cmd_valid[d] = 1'b1;
    cmd[d]       = c;
    cmd_data[d]  = data;
    tick();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_state(input int d, input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (state_o[d] != st && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(state_o[d]), int'(st));
  endtask

  int s, r, x, c, base;

  initial begin
    rst = 1'b1;
    cmd_valid = 2'b00;
    ld = 2'b00;
    ld_val = 8'h00;
    en_cnt[0] = 0;
    en_cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      cmd[i] = 2'b00;
      cmd_data[i] = 8'h00;
    end
    repeat (3) tick();

    for (int d = 0; d < 2; d++) begin
      chk("rst_state",     int'(state_o[d]),   0);
      chk("rst_cmd_ready", int'(cmd_ready[d]), 1);
      chk("rst_busy",      int'(busy[d]),      0);
      chk("rst_pulses",    int'({cnt_en[d], cnt_clr[d], done[d], err[d]}), 0);
    end
    rst = 1'b0;
    tick();

    // prescale 4, target 03: enables 4,8,12 cycles into RUN, done at 16
    send(0, C_SET, 8'h03);
    s = cyc; r = s + 1;
    push(0, r + 4, K_EN); push(0, r + 8, K_EN); push(0, r + 12, K_EN);
    push(0, r + 16, K_DONE);
    base = en_cnt[0];
    send(0, C_START, 8'h00);
    chk("t1_busy", int'(busy[0]), 1);
    wait_state(0, 3'd4, 40, "t1_done_state");
    chk("t1_done_cyc", cyc, r + 16);
    chk("t1_en_pulses", en_cnt[0] - base, 3);
    chk("t1_count", int'(cnt[0]), 8'h03);

    // DONE ignores START/STOP; CLEAR passes through one CLR cycle
    send(0, C_START, 8'h00);
    chk("t4_start_ignored", int'(state_o[0]), 4);
    send(0, C_STOP, 8'h00);
    chk("t4_stop_ignored", int'(state_o[0]), 4);
    c = cyc;
    push(0, c + 1, K_CLR);
    send(0, C_CLEAR, 8'h00);
    chk("t4_clr_state", int'(state_o[0]), 3);
    chk("t4_clr_ready", int'(cmd_ready[0]), 0);
    send(0, C_START, 8'h00);   // offered during CLR, must not be taken
    chk("t4_idle_state", int'(state_o[0]), 0);
    chk("t4_idle_ready", int'(cmd_ready[0]), 1);
    chk("t4_count_cleared", int'(cnt[0]), 8'h00);

    // STOP on the terminal cycle, SET_TARGET 42 then invalid 1A, resume
    send(0, C_SET, 8'h50);
    s = cyc; r = s + 1;
    send(0, C_START, 8'h00);
    repeat (3) tick();
    send(0, C_STOP, 8'h00);
    chk("t2_pause_state", int'(state_o[0]), 2);
    chk("t2_pause_busy", int'(busy[0]), 0);
    send(0, C_SET, 8'h42);
    push(0, cyc + 1, K_ERR);
    send(0, C_SET, 8'h1A);
    chk("t3_busy_paused", int'(busy[0]), 0);
    tick();
    x = cyc;
    push(0, x + 1, K_EN);
    for (int k = 0; k <= 40; k++) push(0, x + 5 + 4 * k, K_EN);
    push(0, x + 169, K_DONE);
    base = en_cnt[0];
    send(0, C_START, 8'h00);
    chk("t2_resume_busy", int'(busy[0]), 1);
    wait_state(0, 3'd4, 300, "t3_done_state");
    chk("t3_count", int'(cnt[0]), 8'h42);
    chk("t3_en_pulses", en_cnt[0] - base, 42);

    // reset in RUN with p = 2, then reset target 99 runs the full lap
    c = cyc;
    push(0, c + 1, K_CLR);
    send(0, C_CLEAR, 8'h00);
    tick();
    send(0, C_START, 8'h00);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6_state", int'(state_o[0]), 0);
    chk("t6_busy", int'(busy[0]), 0);
    chk("t6_ready", int'(cmd_ready[0]), 1);
    chk("t6_pulses", int'({cnt_en[0], cnt_clr[0], done[0], err[0]}), 0);
    rst = 1'b0;
    tick();
    s = cyc; r = s + 1;
    for (int k = 0; k <= 98; k++) push(0, r + 4 + 4 * k, K_EN);
    push(0, r + 400, K_DONE);
    base = en_cnt[0];
    send(0, C_START, 8'h00);
    wait_state(0, 3'd4, 500, "t6_done_state");
    chk("t6_count", int'(cnt[0]), 8'h99);
    chk("t6_en_pulses", en_cnt[0] - base, 99);

    // prescale 1, counter 98, target 02: wraps through 99, 00, 01, 02
    ld[1] = 1'b1;
    ld_val = 8'h98;
    tick();
    ld[1] = 1'b0;
    send(1, C_SET, 8'h02);
    s = cyc; r = s + 1;
    for (int k = 1; k <= 4; k++) push(1, r + k, K_EN);
    push(1, r + 5, K_DONE);
    base = en_cnt[1];
    send(1, C_START, 8'h00);
    wait_state(1, 3'd4, 20, "t5_done_state");
    chk("t5_count", int'(cnt[1]), 8'h02);
    chk("t5_en_pulses", en_cnt[1] - base, 4);

    // target equal to count at START: done with zero enables
    c = cyc;
    push(1, c + 1, K_CLR);
    send(1, C_CLEAR, 8'h00);
    tick();
    send(1, C_SET, 8'h00);
    s = cyc; r = s + 1;
    push(1, r + 1, K_DONE);
    base = en_cnt[1];
    send(1, C_START, 8'h00);
    wait_state(1, 3'd4, 10, "teq_done_state");
    chk("teq_en_pulses", en_cnt[1] - base, 0);

    repeat (3) tick();
    chk("leftover_dut0", q0.size(), 0);
    chk("leftover_dut1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
